pipeline_hazard_controller: RTL and testbench

- Central sequencer for the 5-stage pipeline.
- Each cycle it drives a state to every inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Those drives come from cache handshakes, load-use hazards, taken branches/jumps resolved in MEM, and halt.
- It holds a small FSM for data-memory waits and halt, plus a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_hazard_controller.sv | 105 ++++++++++
 tb/tb_pipeline_hazard_controller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: drives the inter-stage latch commands and PC enable from
// cache handshakes, load-use hazards, MEM-stage redirects and halt.
module pipeline_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             m_dREN,
  input  logic             m_dWEN,
  input  logic             m_halt,
  input  logic             m_redirect,
  input  logic             e_dREN,
  input  logic [4:0]       e_regWSEL,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  output logic             pc_en,
  output logic [1:0]       ifid_state,
  output logic [1:0]       idex_state,
  output logic [1:0]       exmem_state,
  output logic [1:0]       memwb_state,
  output logic             dmem_ren,
  output logic             dmem_wen,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  // state | meaning
  // RUN   | normal issue; hazards resolved by priority decode
  // DWAIT | data access outstanding; pipe frozen until dhit
  // HALT  | core stopped; sticky until reset
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  localparam logic [1:0] PIPE_ENABLE = 2'd0;
  localparam logic [1:0] PIPE_STALL  = 2'd1;
  localparam logic [1:0] PIPE_NOP    = 2'd2;

  state_t state;
  state_t state_next;
  logic   memop;
  logic   loaduse;

  assign memop   = m_dREN | m_dWEN;
  assign loaduse = e_dREN && (e_regWSEL != 5'd0) &&
                   ((e_regWSEL == d_rs) || (e_regWSEL == d_rt));

  // RUN and DWAIT share one decode; DWAIT is left the cycle dhit arrives.
  always_comb begin
    state_next  = RUN;
    pc_en       = 1'b1;
    ifid_state  = PIPE_ENABLE;
    idex_state  = PIPE_ENABLE;
    exmem_state = PIPE_ENABLE;
    memwb_state = PIPE_ENABLE;
    if (state == HALT) begin
      state_next  = HALT;
      pc_en       = 1'b0;
      ifid_state  = PIPE_STALL;
      idex_state  = PIPE_STALL;
      exmem_state = PIPE_STALL;
      memwb_state = PIPE_STALL;
    end else if (m_halt) begin
      state_next  = HALT;
      pc_en       = 1'b0;
      ifid_state  = PIPE_NOP;
      idex_state  = PIPE_NOP;
      exmem_state = PIPE_NOP;
    end else if (memop && !dhit) begin
      state_next  = DWAIT;
      pc_en       = 1'b0;
      ifid_state  = PIPE_STALL;
      idex_state  = PIPE_STALL;
      exmem_state = PIPE_STALL;
      memwb_state = PIPE_NOP;
    end else if (m_redirect) begin
      ifid_state  = PIPE_NOP;
      idex_state  = PIPE_NOP;
      exmem_state = PIPE_NOP;
    end else if (loaduse) begin
      pc_en       = 1'b0;
      ifid_state  = PIPE_STALL;
      idex_state  = PIPE_NOP;
    end else if (!ihit) begin
      pc_en       = 1'b0;
      ifid_state  = PIPE_NOP;
    end
  end

  assign halted   = (state == HALT);
  assign dmem_ren = m_dREN && (state != HALT);
  assign dmem_wen = m_dWEN && (state != HALT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= RUN;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      if ((state != HALT) && !pc_en && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller; expected responses are
// queued by the driver and compared by an independent negedge monitor.
module tb_pipeline_hazard_controller;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, m_dREN, m_dWEN, m_halt, m_redirect, e_dREN;
  logic [4:0]       e_regWSEL, d_rs, d_rt;
  logic             pc_en, dmem_ren, dmem_wen, halted;
  logic [1:0]       ifid_state, idex_state, exmem_state, memwb_state;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .m_dREN(m_dREN),
    .m_dWEN(m_dWEN), .m_halt(m_halt), .m_redirect(m_redirect), .e_dREN(e_dREN),
    .e_regWSEL(e_regWSEL), .d_rs(d_rs), .d_rt(d_rt), .pc_en(pc_en),
    .ifid_state(ifid_state), .idex_state(idex_state), .exmem_state(exmem_state),
    .memwb_state(memwb_state), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string            name;
    logic [14:0]      outs;  // {pc_en, ifid, idex, exmem, memwb, ren, wen, halted}
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // ctl = {ihit, dhit, m_dREN, m_dWEN, m_halt, m_redirect}
  task automatic vec(input logic rst_n, input logic [5:0] ctl, input logic ed,
                     input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
                     input logic pc, input logic [1:0] f, input logic [1:0] d,
                     input logic [1:0] x, input logic [1:0] w, input logic rd,
                     input logic wr, input logic hl, input int cnt, input string name);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST = rst_n;
    {ihit, dhit, m_dREN, m_dWEN, m_halt, m_redirect} = ctl;
    e_dREN = ed; e_regWSEL = ws; d_rs = rs; d_rt = rt;
    e.name = name;
    e.outs = {pc, f, d, x, w, rd, wr, hl, 3'b000};
    e.cnt  = CNT_W'(cnt);
    q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e = q.pop_front();
      act = {pc_en, ifid_state, idex_state, exmem_state, memwb_state,
             dmem_ren, dmem_wen, halted, 3'b000};
      checks++;
      if (act !== e.outs || stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL %s: got pc_en/ifid/idex/exmem/memwb/ren/wen/halted=%b cnt=%0d, want %b cnt=%0d",
                 e.name, act[14:3], stall_cycles, e.outs[14:3], e.cnt);
      end
    end
  end

  initial begin
    nRST = 1'b0;
    {ihit, dhit, m_dREN, m_dWEN, m_halt, m_redirect, e_dREN} = '0;
    e_regWSEL = '0; d_rs = '0; d_rt = '0;

    vec(0, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 4; i++)
      vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

    vec(1, 6'b100000, 1, 8, 0, 8, 0, 1, 2, 0, 0, 0, 0, 0, 0, "loaduse_rt");
    vec(1, 6'b100000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "loaduse_r0");
    vec(1, 6'b100000, 1, 8, 8, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, "loaduse_rs");
    vec(1, 6'b100000, 0, 8, 8, 8, 1, 0, 0, 0, 0, 0, 0, 0, 2, "no_load");

    vec(1, 6'b101000, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1, 0, 0, 2, "dwait1");
    vec(1, 6'b101000, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1, 0, 0, 3, "dwait2");
    vec(1, 6'b101000, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1, 0, 0, 4, "dwait3");
    vec(1, 6'b111000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 5, "dhit");
    vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5, "post_dhit");

    vec(1, 6'b100101, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 1, 0, 5, "st_redir_wait");
    vec(1, 6'b110101, 0, 0, 0, 0, 1, 2, 2, 2, 0, 0, 1, 0, 6, "st_redir_go");
    vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6, "post_redir");

    vec(1, 6'b000001, 0, 0, 0, 0, 1, 2, 2, 2, 0, 0, 0, 0, 6, "redir_noihit");
    vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6, "redir_run");
    vec(1, 6'b000000, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 6, "imiss");
    vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 7, "post_imiss");
    vec(1, 6'b000000, 1, 8, 0, 8, 0, 1, 2, 0, 0, 0, 0, 0, 7, "loaduse_imiss");
    vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8, "post_lu_imiss");

    vec(1, 6'b100011, 1, 8, 8, 0, 0, 2, 2, 2, 0, 0, 0, 0, 8, "halt_prio");
    vec(1, 6'b101100, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 9, "halted");
    vec(1, 6'b111111, 1, 8, 8, 0, 0, 1, 1, 1, 1, 0, 0, 1, 9, "halt_sticky");
    vec(0, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid_halt");
    vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst");

    for (int i = 0; i < 20; i++)
      vec(1, 6'b000000, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, (i > 15) ? 15 : i, "sat");
    vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 15, "sat_hold1");
    vec(1, 6'b100000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 15, "sat_hold2");

    repeat (3) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: got no completion by 20000, want completion");
      $fatal(1, "timeout");
    end
  end

endmodule
